// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point sequence checker and generator.
// Holds the controller state type, IEEE-754 single-precision constants, and
// helpers that extract fields and order encodings for ULP distance checks.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] f);
    return f[22:0];
  endfunction

  function automatic int fp_unbiased_exp(input logic [31:0] f);
    return int'(f[30:23]) - EXP_BIAS;
  endfunction

  // Sign-magnitude encoding mapped onto a signed integer line, so adjacent
  // floats differ by one and +0 / -0 coincide.
  function automatic logic signed [32:0] fp_ordered(input logic [31:0] f);
    logic signed [32:0] mag;
    mag = {2'b00, f[30:0]};
    return f[31] ? -mag : mag;
  endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision adder/subtractor.
// Ports:
//   a, b    : operands
//   op      : 0 = a + b, 1 = a - b
//   result  : round-to-nearest-even sum; denormal inputs/results flush to +0,
//             an exact zero result is always +0, overflow saturates to Inf
//   invalid : either operand is NaN or Inf (result then forced to +0)
module fp_addsub
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] result,
  output logic        invalid
);

  logic              sa, sb, sx, sy;
  logic [7:0]        ea, eb, ex, ey, shift;
  logic [23:0]       ma, mb, mx, my;
  logic [26:0]       x_ext, y_ext, y_sh, norm;
  logic              sticky, found, round_up;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [24:0]       mant_r;
  logic [22:0]       frac;

  always_comb begin
    sa      = fp_sign(a);
    sb      = fp_sign(b) ^ op;
    ea      = fp_exp(a);
    eb      = fp_exp(b);
    invalid = (ea == EXP_MAX) || (eb == EXP_MAX);
    ma      = (ea == 8'd0) ? 24'd0 : {1'b1, fp_man(a)};
    mb      = (eb == 8'd0) ? 24'd0 : {1'b1, fp_man(b)};

    // x is the operand of larger magnitude; it sets the result sign
    if ({ea, ma} >= {eb, mb}) begin
      sx = sa; ex = ea; mx = ma;
      sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb;
      sy = sa; ey = ea; my = ma;
    end

    // three extra bits: guard, round, sticky
    shift = ex - ey;
    x_ext = {mx, 3'b000};
    y_ext = {my, 3'b000};
    if (shift >= 8'd27) begin
      y_sh   = 27'd0;
      sticky = |y_ext;
    end else begin
      y_sh   = y_ext >> shift;
      sticky = |(y_ext & ((27'd1 << shift) - 27'd1));
    end
    y_sh[0] = y_sh[0] | sticky;

    sum = (sx == sy) ? ({1'b0, x_ext} + {1'b0, y_sh})
                     : ({1'b0, x_ext} - {1'b0, y_sh});

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + 5'd1;
      end
    end

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, ex}) - $signed({5'd0, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      exp_n = exp_n + 10'sd1;
      frac  = mant_r[23:1];
    end else begin
      frac  = mant_r[22:0];
    end

    if (invalid || (sum == 28'd0) || (exp_n <= 10'sd0))
      result = FP_ZERO;
    else if (exp_n >= 10'sd255)
      result = {sx, EXP_MAX, 23'd0};
    else
      result = {sx, exp_n[7:0], frac};
  end

endmodule

// File: rtl/fp_sequence_checker.sv
// Checks that a stream of single-precision terms forms an arithmetic sequence.
// The first difference becomes the reference d_out; every later difference
// is compared against it within ULP_TOL and mismatches are counted.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   enable              : arms the checker; dropping it aborts a run
//   term_in/term_valid  : one term per cycle, back-to-back allowed
//   term_done           : end of sequence (may coincide with last term)
//   a1_out, d_out       : first term, reference difference
//   term_count          : terms accepted
//   err_count           : saturating mismatch count
//   seq_ok              : no mismatches and no NaN/Inf operand
//   result_valid, busy  : report pulse, run in progress
//
// state      | meaning
// ST_IDLE    | waiting for enable; results of the last run held
// ST_COLLECT | accepting terms until term_done
// ST_DRAIN   | two cycles letting the difference pipeline empty
// ST_REPORT  | result_valid pulse, outputs final
module fp_sequence_checker
  import fp_pkg::*;
#(
  parameter int ERR_W   = 16,
  parameter int ULP_TOL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      term_in,
  input  logic             term_valid,
  input  logic             term_done,
  output logic [31:0]      a1_out,
  output logic [31:0]      d_out,
  output logic [31:0]      term_count,
  output logic [ERR_W-1:0] err_count,
  output logic             seq_ok,
  output logic             result_valid,
  output logic             busy
);

  state_t      state, state_nxt;
  logic        drain_cnt;
  logic [31:0] prev_term, diff_r, diff;
  logic        s1_valid, s1_k2, s1_inv, diff_inv, bad_op;
  logic        start, accept, mismatch;

  logic signed [32:0] ord_new, ord_ref;
  logic signed [33:0] delta;
  logic [33:0]        mag;

  fp_addsub u_sub (
    .a       (term_in),
    .b       (prev_term),
    .op      (1'b1),
    .result  (diff),
    .invalid (diff_inv)
  );

  assign start  = (state == ST_IDLE) && enable;
  assign accept = (state == ST_COLLECT) && term_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (!enable)        state_nxt = ST_IDLE;
        else if (term_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!enable)                state_nxt = ST_IDLE;
        else if (drain_cnt == 1'b0) state_nxt = ST_REPORT;
      end
      ST_REPORT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == ST_COLLECT) || (state == ST_DRAIN);
    result_valid = (state == ST_REPORT);
    seq_ok       = (err_count == '0) && !bad_op;
  end

  always_comb begin
    ord_new  = fp_ordered(diff_r);
    ord_ref  = fp_ordered(d_out);
    delta    = 34'(ord_new) - 34'(ord_ref);
    mag      = delta[33] ? -delta : delta;
    mismatch = mag > 34'(ULP_TOL);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      a1_out     <= FP_ZERO;
      d_out      <= FP_ZERO;
      term_count <= 32'd0;
      err_count  <= '0;
      bad_op     <= 1'b0;
      prev_term  <= FP_ZERO;
      diff_r     <= FP_ZERO;
      s1_valid   <= 1'b0;
      s1_k2      <= 1'b0;
      s1_inv     <= 1'b0;
      drain_cnt  <= 1'b0;
    end else begin
      if (state == ST_COLLECT && state_nxt == ST_DRAIN) drain_cnt <= 1'b1;
      else if (state == ST_DRAIN && drain_cnt)          drain_cnt <= 1'b0;

      // stage 1: difference against the previous term
      s1_valid <= 1'b0;
      if (accept) begin
        term_count <= term_count + 32'd1;
        prev_term  <= term_in;
        if (term_count == 32'd0) begin
          a1_out <= term_in;
        end else begin
          diff_r   <= diff;
          s1_valid <= 1'b1;
          s1_k2    <= (term_count == 32'd1);
          s1_inv   <= diff_inv;
          if (diff_inv) bad_op <= 1'b1;
        end
      end

      // stage 2: first difference is the reference, later ones are checked
      if (s1_valid) begin
        if (s1_k2)
          d_out <= diff_r;
        else if (!s1_inv && mismatch && (err_count != '1))
          err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_sequence_checker.sv
module tb_fp_sequence_checker;

  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [31:0]   term_in = 32'd0;
  logic          term_valid = 1'b0;
  logic          term_done = 1'b0;
  logic [31:0]   a1_out, d_out, term_count;
  logic [EW-1:0] err_count;
  logic          seq_ok, result_valid, busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] seq_q[$];
  logic [31:0] exp_a1, exp_d;
  int          exp_tc, exp_err;
  bit          exp_ok;

  fp_sequence_checker #(.ERR_W(EW), .ULP_TOL(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .term_in      (term_in),
    .term_valid   (term_valid),
    .term_done    (term_done),
    .a1_out       (a1_out),
    .d_out        (d_out),
    .term_count   (term_count),
    .err_count    (err_count),
    .seq_ok       (seq_ok),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // single-precision encoding of n * 2^-scale (|n| < 2^24, exact)
  function automatic logic [31:0] fbits(input int n, input int scale);
    logic [31:0] m;
    int p, e;
    if (n == 0) return 32'd0;
    m = (n < 0) ? 32'(-n) : 32'(n);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = p - scale + 127;
    m = m << (23 - p);
    return {(n < 0), 8'(e), m[22:0]};
  endfunction

  // reference: first difference is d, every later differing step is an error
  task automatic model_ints(input int v[$], input int scale);
    int e;
    seq_q.delete();
    foreach (v[i]) seq_q.push_back(fbits(v[i], scale));
    exp_tc = v.size();
    exp_a1 = (v.size() > 0) ? fbits(v[0], scale) : 32'd0;
    exp_d  = (v.size() > 1) ? fbits(v[1] - v[0], scale) : 32'd0;
    e = 0;
    for (int k = 2; k < v.size(); k++)
      if ((v[k] - v[k-1]) != (v[1] - v[0])) e++;
    exp_err = (e > 7) ? 7 : e;
    exp_ok  = (e == 0);
  endtask

  task automatic run_seq(input string tag, input bit dwl, input int max_gap, input bit chk_data);
    bit seen;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b exp 1", tag, busy); end
    foreach (seq_q[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        term_valid = 1'b0;
        @(negedge clk);
      end
      term_in    = seq_q[i];
      term_valid = 1'b1;
      term_done  = dwl && (i == seq_q.size() - 1);
      @(negedge clk);
    end
    term_valid = 1'b0;
    if (!dwl || seq_q.size() == 0) begin
      term_done = 1'b1;
      @(negedge clk);
    end
    term_done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (result_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s result_valid timeout got none exp pulse", tag);
    end else begin
      if (chk_data) begin
        checks += 3;
        if (a1_out !== exp_a1) begin errors++; $display("FAIL %s a1_out got %h exp %h", tag, a1_out, exp_a1); end
        if (d_out !== exp_d) begin errors++; $display("FAIL %s d_out got %h exp %h", tag, d_out, exp_d); end
        if (err_count !== EW'(exp_err)) begin errors++; $display("FAIL %s err_count got %0d exp %0d", tag, err_count, exp_err); end
      end
      checks += 2;
      if (term_count !== 32'(exp_tc)) begin errors++; $display("FAIL %s term_count got %0d exp %0d", tag, term_count, exp_tc); end
      if (seq_ok !== exp_ok) begin errors++; $display("FAIL %s seq_ok got %b exp %b", tag, seq_ok, exp_ok); end
      enable = 1'b0;
      @(negedge clk);
      checks += 2;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL %s pulse_width got %b exp 0", tag, result_valid); end
      if (term_count !== 32'(exp_tc)) begin errors++; $display("FAIL %s hold term_count got %0d exp %0d", tag, term_count, exp_tc); end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a1_out, d_out, term_count, err_count, result_valid, busy} !== '0 || seq_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset outputs got a1=%h d=%h tc=%0d err=%0d ok=%b rv=%b busy=%b exp zeros ok=1",
               a1_out, d_out, term_count, err_count, seq_ok, result_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    seq_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    exp_a1 = 32'h3F800000; exp_d = 32'h3F800000; exp_tc = 5; exp_err = 0; exp_ok = 1;
    run_seq("ramp", 1'b1, 0, 1'b1);

    seq_q = '{32'h41200000, 32'h41180000, 32'h41100000, 32'h41080000, 32'h41000000};
    exp_a1 = 32'h41200000; exp_d = 32'hBF000000; exp_tc = 5; exp_err = 0; exp_ok = 1;
    run_seq("descend", 1'b1, 0, 1'b1);

    seq_q = '{32'hC0A00000, 32'hC0200000, 32'h00000000, 32'h40200000, 32'h40A00000};
    exp_a1 = 32'hC0A00000; exp_d = 32'h40200000; exp_tc = 5; exp_err = 0; exp_ok = 1;
    run_seq("cross_zero", 1'b0, 0, 1'b1);

    seq_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000, 32'h40C00000};
    exp_a1 = 32'h3F800000; exp_d = 32'h3F800000; exp_tc = 5; exp_err = 1; exp_ok = 0;
    run_seq("one_gap", 1'b1, 0, 1'b1);

    seq_q = '{32'h4048F5C3};
    exp_a1 = 32'h4048F5C3; exp_d = 32'h0; exp_tc = 1; exp_err = 0; exp_ok = 1;
    run_seq("single", 1'b0, 0, 1'b1);

    seq_q.delete();
    exp_a1 = 32'h0; exp_d = 32'h0; exp_tc = 0; exp_err = 0; exp_ok = 1;
    run_seq("empty", 1'b0, 0, 1'b1);

    seq_q = '{32'h3F800000, 32'h7FC00000, 32'h40000000};
    exp_tc = 3; exp_ok = 0;
    run_seq("nan", 1'b1, 0, 1'b0);
  endtask

  task automatic test_saturation();
    int v[$];
    v = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66};
    model_ints(v, 0);
    run_seq("saturate", 1'b1, 0, 1'b1);
    checks++;
    if (err_count !== 3'd7) begin errors++; $display("FAIL saturate err_count got %0d exp 7", err_count); end
  endtask

  task automatic test_abort_and_ignore();
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      term_in = fbits(i, 0); term_valid = 1'b1;
      @(negedge clk);
    end
    term_valid = 1'b0;
    enable = 1'b0;
    begin
      bit pulsed = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (result_valid !== 1'b0) pulsed = 1'b1;
      end
      checks++;
      if (pulsed) begin errors++; $display("FAIL abort result_valid got pulse exp none"); end
    end
    checks += 2;
    if (term_count !== 32'd3) begin errors++; $display("FAIL abort term_count got %0d exp 3", term_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b exp 0", busy); end
    term_in = 32'h40000000; term_valid = 1'b1;
    repeat (3) @(negedge clk);
    term_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (term_count !== 32'd3) begin errors++; $display("FAIL idle_ignore term_count got %0d exp 3", term_count); end
  endtask

  task automatic test_mid_reset();
    bit pulsed;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      term_in = fbits(i, 0); term_valid = 1'b1;
      @(negedge clk);
    end
    term_valid = 1'b0;
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a1_out, d_out, term_count, err_count, result_valid, busy} !== '0 || seq_ok !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset outputs got a1=%h d=%h tc=%0d err=%0d ok=%b rv=%b busy=%b exp zeros ok=1",
               a1_out, d_out, term_count, err_count, seq_ok, result_valid, busy);
    end
    rst = 1'b0;
    pulsed = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (result_valid !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin errors++; $display("FAIL mid_reset result_valid got pulse exp none"); end
    seq_q = '{32'h3F800000, 32'h40000000};
    exp_a1 = 32'h3F800000; exp_d = 32'h3F800000; exp_tc = 2; exp_err = 0; exp_ok = 1;
    run_seq("after_reset", 1'b1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      int v[$];
      int n, a, d, scale;
      n     = $urandom_range(1, 9);
      a     = int'($urandom_range(0, 4000)) - 2000;
      d     = int'($urandom_range(0, 600)) - 300;
      scale = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) v.push_back(a + k * d);
      if (n > 1 && $urandom_range(0, 1) == 1) begin
        int idx = $urandom_range(1, n - 1);
        v[idx] = v[idx] + int'($urandom_range(1, 5)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
      end
      model_ints(v, scale);
      run_seq($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), (r % 2 == 0) ? 0 : 2, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_abort_and_ignore();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
